// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared defaults, width helper and stored-word layout for the trace collector
package trace_pkg;

   localparam int DEF_NCH     = 5;
   localparam int DEF_TRACE_W = 32;
   localparam int DEF_FIFO_D  = 4;
   localparam int DEF_CNT_W   = 16;

   // Stored FIFO word is {lost, data}: the lost flag sits in the MSB above the payload.
   localparam int LOST_W = 1;

   function automatic int clog2_min1(input int n);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < n) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/trace_collector_if.sv
// rtl/trace_collector_if.sv - merged trace output stream toward the trace buffer
interface trace_collector_if
   import trace_pkg::*;
#(
   parameter int TRACE_W = DEF_TRACE_W,
   parameter int CH_W    = clog2_min1(DEF_NCH)
);
   logic               out_valid;
   logic               out_ready;
   logic [TRACE_W-1:0] out_data;
   logic [CH_W-1:0]    out_ch;
   logic               out_lost;

   modport master (output out_valid, out_data, out_ch, out_lost, input out_ready);
   modport slave  (input out_valid, out_data, out_ch, out_lost, output out_ready);
endinterface

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - per-channel trace FIFO with simultaneous push/pop and full/empty flags
module trace_fifo
   import trace_pkg::*;
#(
   parameter int WIDTH = DEF_TRACE_W + LOST_W,
   parameter int DEPTH = DEF_FIFO_D
)
(
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic [WIDTH-1:0] i_wdata,
   output logic [WIDTH-1:0] o_rdata,
   output logic             o_full,
   output logic             o_empty
);
   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wptr;
   logic [AW:0]      r_rptr;

   // Extra pointer bit distinguishes full from empty when the index bits match.
   assign o_empty = (r_wptr == r_rptr);
   assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
   assign o_rdata = r_mem[r_rptr[AW-1:0]];

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_push) r_wptr <= r_wptr + (AW+1)'(1);
         if (i_pop)  r_rptr <= r_rptr + (AW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
   end

endmodule

// File: rtl/trace_collector.sv
// rtl/trace_collector.sv - per-channel trace FIFOs merged round-robin into one output stream
module trace_collector
   import trace_pkg::*;
#(
   parameter int NCH     = DEF_NCH,
   parameter int TRACE_W = DEF_TRACE_W,
   parameter int FIFO_D  = DEF_FIFO_D,
   parameter int CNT_W   = DEF_CNT_W
)
(
   input  logic                   i_clk,
   input  logic                   i_rst_n,
   input  logic [NCH-1:0]         i_trigger,
   input  logic [NCH*TRACE_W-1:0] i_trace,
   input  logic [NCH-1:0]         i_ch_en,
   input  logic [NCH-1:0]         i_ovf_clr,
   output logic [NCH-1:0]         o_ovf,
   output logic [CNT_W-1:0]       o_drop_cnt,
   trace_collector_if.master      o_out
);
   localparam int CH_W   = clog2_min1(NCH);
   localparam int WORD_W = TRACE_W + LOST_W;

   logic [NCH-1:0]    w_empty;
   logic [NCH-1:0]    w_full;
   logic [NCH-1:0]    w_push_req;
   logic [NCH-1:0]    w_push;
   logic [NCH-1:0]    w_pop;
   logic [NCH-1:0]    w_drop;
   logic [WORD_W-1:0] w_rdata [NCH];

   logic [NCH-1:0]    r_lost_pend;
   logic [NCH-1:0]    r_ovf;
   logic [CNT_W-1:0]  r_drop_cnt;
   logic [CH_W-1:0]   r_last_grant;

   logic [CH_W-1:0]   w_grant;
   logic              w_found;
   logic              w_can_load;
   logic              w_load;
   logic [CNT_W:0]    w_cnt_sum;

   assign w_can_load = !o_out.out_valid || o_out.out_ready;
   assign w_load     = w_can_load && w_found;

   for (genvar g = 0; g < NCH; g++) begin : g_ch
      assign w_push_req[g] = i_trigger[g] && i_ch_en[g];
      assign w_pop[g]      = w_load && (w_grant == CH_W'(g));
      // A pop in the same cycle frees the slot, so a full FIFO still accepts.
      assign w_push[g]     = w_push_req[g] && (!w_full[g] || w_pop[g]);
      assign w_drop[g]     = w_push_req[g] && w_full[g] && !w_pop[g];

      trace_fifo #(
         .WIDTH (WORD_W),
         .DEPTH (FIFO_D)
      ) u_fifo (
         .i_clk   (i_clk),
         .i_rst_n (i_rst_n),
         .i_push  (w_push[g]),
         .i_pop   (w_pop[g]),
         .i_wdata ({r_lost_pend[g], i_trace[g*TRACE_W +: TRACE_W]}),
         .o_rdata (w_rdata[g]),
         .o_full  (w_full[g]),
         .o_empty (w_empty[g])
      );
   end

   always_comb begin : p_arb
      int idx;
      idx     = 0;
      w_found = 1'b0;
      w_grant = '0;
      for (int k = 0; k < NCH; k++) begin
         idx = int'(r_last_grant) + 1 + k;
         if (idx >= NCH) idx = idx - NCH;
         if (!w_found && !w_empty[CH_W'(idx)]) begin
            w_found = 1'b1;
            w_grant = CH_W'(idx);
         end
      end
   end

   // Simultaneous drops from several channels land in one update, then saturate.
   always_comb begin
      w_cnt_sum = {1'b0, r_drop_cnt};
      for (int i = 0; i < NCH; i++) begin
         w_cnt_sum = w_cnt_sum + (CNT_W+1)'(w_drop[i]);
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_lost_pend <= '0;
         r_ovf       <= '0;
         r_drop_cnt  <= '0;
      end else begin
         r_lost_pend <= (r_lost_pend & ~w_push) | w_drop;
         r_ovf       <= (r_ovf & ~i_ovf_clr) | w_drop;
         r_drop_cnt  <= w_cnt_sum[CNT_W] ? {CNT_W{1'b1}} : w_cnt_sum[CNT_W-1:0];
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_out.out_valid <= 1'b0;
         o_out.out_data  <= '0;
         o_out.out_ch    <= '0;
         o_out.out_lost  <= 1'b0;
         r_last_grant    <= CH_W'(NCH - 1);
      end else if (w_can_load) begin
         if (w_found) begin
            o_out.out_valid <= 1'b1;
            o_out.out_data  <= w_rdata[w_grant][TRACE_W-1:0];
            o_out.out_lost  <= w_rdata[w_grant][TRACE_W];
            o_out.out_ch    <= w_grant;
            r_last_grant    <= w_grant;
         end else begin
            o_out.out_valid <= 1'b0;
         end
      end
   end

   assign o_ovf      = r_ovf;
   assign o_drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_trace_collector.sv
// tb/tb_trace_collector.sv - randomized bench for trace_collector against a queue-based reference model
module tb_trace_collector;
   localparam int NCH = 5;
   localparam int TW  = 32;
   localparam int FD  = 4;
   localparam int CW  = 16;
   localparam int CHW = 3;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic [NCH-1:0]    trigger = '0;
   logic [NCH*TW-1:0] trace = '0;
   logic [NCH-1:0]    ch_en = '0;
   logic [NCH-1:0]    ovf_clr = '0;
   logic [NCH-1:0]    ovf;
   logic [CW-1:0]     drop_cnt;

   trace_collector_if #(.TRACE_W(TW), .CH_W(CHW)) out_if ();

   trace_collector #(
      .NCH     (NCH),
      .TRACE_W (TW),
      .FIFO_D  (FD),
      .CNT_W   (CW)
   ) dut (
      .i_clk      (clk),
      .i_rst_n    (rst_n),
      .i_trigger  (trigger),
      .i_trace    (trace),
      .i_ch_en    (ch_en),
      .i_ovf_clr  (ovf_clr),
      .o_ovf      (ovf),
      .o_drop_cnt (drop_cnt),
      .o_out      (out_if)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: one queue of {lost, data} per channel plus the output register contents.
   logic [TW:0]    mq [NCH][$];
   bit             m_valid;
   logic [TW-1:0]  m_data;
   int             m_ch;
   bit             m_lost;
   int             m_last;
   bit [NCH-1:0]   m_ovf;
   bit [NCH-1:0]   m_pend;
   int             m_drops;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < NCH; i++) mq[i].delete();
      m_valid = 0;
      m_data  = '0;
      m_ch    = 0;
      m_lost  = 0;
      m_last  = NCH - 1;
      m_ovf   = '0;
      m_pend  = '0;
      m_drops = 0;
   endtask

   task automatic model_step();
      int          win;
      int          nd;
      bit [NCH-1:0] dm;
      logic [TW:0] w;
      win = -1;
      if (!m_valid || out_if.out_ready) begin
         for (int k = 0; k < NCH; k++) begin
            int c;
            c = (m_last + 1 + k) % NCH;
            if (win < 0 && mq[c].size() > 0) win = c;
         end
         if (win >= 0) begin
            w       = mq[win].pop_front();
            m_data  = w[TW-1:0];
            m_lost  = w[TW];
            m_ch    = win;
            m_valid = 1;
            m_last  = win;
         end else begin
            m_valid = 0;
         end
      end
      nd = 0;
      dm = '0;
      for (int i = 0; i < NCH; i++) begin
         if (trigger[i] && ch_en[i]) begin
            if (mq[i].size() < FD) begin
               mq[i].push_back({m_pend[i], trace[i*TW +: TW]});
               m_pend[i] = 0;
            end else begin
               dm[i]     = 1;
               m_pend[i] = 1;
               nd++;
            end
         end
      end
      m_ovf   = (m_ovf & ~ovf_clr) | dm;
      m_drops = (m_drops + nd > 65535) ? 65535 : m_drops + nd;
   endtask

   task automatic compare_all();
      check("out_valid", out_if.out_valid, m_valid);
      if (m_valid) begin
         check("out_data", out_if.out_data, m_data);
         check("out_ch",   out_if.out_ch,   m_ch);
         check("out_lost", out_if.out_lost, m_lost);
      end
      check("ovf",      ovf,      m_ovf);
      check("drop_cnt", drop_cnt, m_drops);
   endtask

   task automatic cycle();
      @(posedge clk);
      model_step();
      #1;
      compare_all();
   endtask

   task automatic rand_trace();
      for (int i = 0; i < NCH; i++) trace[i*TW +: TW] = $urandom;
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_valid"}, out_if.out_valid, 0);
      check({tag, "_data"},  out_if.out_data,  0);
      check({tag, "_ch"},    out_if.out_ch,    0);
      check({tag, "_lost"},  out_if.out_lost,  0);
      check({tag, "_ovf"},   ovf,              0);
      check({tag, "_drop"},  drop_cnt,         0);
   endtask

   task automatic do_reset();
      trigger = '0;
      ovf_clr = '0;
      ch_en   = '1;
      out_if.out_ready = 1'b0;
      rst_n = 1'b0;
      model_reset();
      @(posedge clk);
      #1;
      check_zero("rst");
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int  exp_ch;
      bit  seen_lost;
      int  ready_pct;

      out_if.out_ready = 1'b0;
      do_reset();

      // Single word on channel 2
      out_if.out_ready = 1'b1;
      trigger = 5'b00100;
      trace[2*TW +: TW] = 32'hDEADBEEF;
      cycle();
      check("single_lat1_valid", out_if.out_valid, 0);
      trigger = '0;
      cycle();
      check("single_valid", out_if.out_valid, 1);
      check("single_data",  out_if.out_data,  32'hDEADBEEF);
      check("single_ch",    out_if.out_ch,    2);
      check("single_lost",  out_if.out_lost,  0);
      for (int n = 0; n < 3; n++) cycle();

      // Fairness: every channel triggers every cycle
      do_reset();
      out_if.out_ready = 1'b1;
      exp_ch = 0;
      for (int n = 0; n < 30; n++) begin
         trigger = '1;
         rand_trace();
         cycle();
         if (out_if.out_valid) begin
            check("rr_seq", out_if.out_ch, exp_ch);
            exp_ch = (exp_ch + 1) % NCH;
         end
      end
      trigger = '0;
      for (int n = 0; n < 25; n++) cycle();

      // Overflow on channel 1 with the output stalled
      do_reset();
      for (int n = 0; n < 7; n++) begin
         trigger = 5'b00010;
         trace[1*TW +: TW] = 32'h1000 + n;
         cycle();
      end
      trigger = '0;
      check("ovf1_flag", ovf[1], 1);
      check("ovf1_drops", drop_cnt, 2);
      out_if.out_ready = 1'b1;
      cycle();
      trigger = 5'b00010;
      trace[1*TW +: TW] = 32'h2000;
      cycle();
      trigger = '0;
      seen_lost = 0;
      for (int n = 0; n < 12; n++) begin
         cycle();
         if (out_if.out_valid && out_if.out_lost && out_if.out_ch == 1) seen_lost = 1;
      end
      check("ovf1_lost_seen", seen_lost, 1);

      // Set beats clear on channel 3, then disabled channel ignores triggers
      do_reset();
      ovf_clr = 5'b01000;
      for (int n = 0; n < 7; n++) begin
         trigger = 5'b01000;
         trace[3*TW +: TW] = 32'h3000 + n;
         cycle();
      end
      trigger = '0;
      check("ovf3_set_wins", ovf[3], 1);
      check("ovf3_drops", drop_cnt, 2);
      cycle();
      check("ovf3_cleared", ovf[3], 0);
      ovf_clr = '0;
      out_if.out_ready = 1'b1;
      ch_en = 5'b10111;
      for (int n = 0; n < 12; n++) begin
         trigger = 5'b01000;
         rand_trace();
         cycle();
      end
      trigger = '0;
      check("ch3_disabled_idle", out_if.out_valid, 0);
      ch_en = '1;

      // Randomized traffic with varying backpressure
      do_reset();
      ready_pct = 50;
      for (int n = 0; n < 3000; n++) begin
         if (n % 200 == 0) begin
            case ($urandom_range(0, 2))
               0: ready_pct = 10;
               1: ready_pct = 50;
               default: ready_pct = 95;
            endcase
         end
         trigger = NCH'($urandom);
         for (int i = 0; i < NCH; i++) ch_en[i] = ($urandom_range(0, 7) != 0);
         ovf_clr = ($urandom_range(0, 15) == 0) ? NCH'($urandom) : '0;
         out_if.out_ready = ($urandom_range(0, 99) < ready_pct);
         rand_trace();
         cycle();
      end
      trigger = '0;
      ovf_clr = '0;
      out_if.out_ready = 1'b1;
      for (int n = 0; n < 30; n++) cycle();

      // Reset in the middle of buffered traffic
      do_reset();
      for (int n = 0; n < 3; n++) begin
         trigger = 5'b00111;
         rand_trace();
         cycle();
      end
      trigger = '0;
      check("mid_pre_valid", out_if.out_valid, 1);
      rst_n = 1'b0;
      #1;
      check_zero("mid_rst");
      model_reset();
      @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      out_if.out_ready = 1'b1;
      for (int n = 0; n < 10; n++) begin
         cycle();
         check("mid_after_idle", out_if.out_valid, 0);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/trace_collector.md
TRACE_COLLECTOR -- requirements
Module: trace_collector

Interface
REQ-001 SHALL have parameter NCH, default 5, number of trace channels (4 tiles + NoC).
REQ-002 SHALL have parameter TRACE_W, default 32, trace word width.
REQ-003 SHALL have parameter FIFO_D, default 4, per-channel FIFO depth (power of two, >=2).
REQ-004 SHALL have parameter CNT_W, default 16, drop-counter width.
REQ-005 SHALL derive CHw = log2(NCH) (min 1).
REQ-006 clk  in  1  sole clock, all state on rising edge.
REQ-007 reset  in  1  asynchronous, active-low reset.
REQ-008 trigger  in  NCH  per-channel trace-valid strobe.
REQ-009 trace  in  NCH*TRACE_W  per-channel trace words, channel i at [(i+1)*TRACE_W-1 : i*TRACE_W].
REQ-010 ch_en  in  NCH  per-channel capture enable.
REQ-011 out_valid  out  1  output word available.
REQ-012 out_ready  in  1  downstream (trace buffer) accepts word.
REQ-013 out_data  out  TRACE_W  trace payload.
REQ-014 out_ch  out  CHw  source channel index.
REQ-015 out_lost  out  1  one or more earlier words of out_ch were dropped before this one.
REQ-016 ovf  out  NCH  sticky per-channel overflow flags.
REQ-017 ovf_clr  in  NCH  per-channel overflow clear.
REQ-018 drop_cnt  out  CNT_W  total dropped words, all channels.

Function
REQ-019 SHALL push trace slice i into FIFO i on a clock edge where trigger[i]=1, ch_en[i]=1, FIFO i not full.
REQ-020 SHALL ignore trigger[i] when ch_en[i]=0; FIFO i contents still drain.
REQ-021 SHALL, on push to full FIFO i with no same-cycle pop of i, drop the word, set ovf[i], set lost_pend[i], increment drop_cnt.
REQ-022 SHALL accept push to full FIFO i when FIFO i is popped same cycle (no drop).
REQ-023 SHALL add simultaneous drops from k channels to drop_cnt in one cycle; drop_cnt saturates at 2^CNT_W-1.
REQ-024 SHALL store lost_pend[i] alongside the next successfully pushed word of channel i, then clear lost_pend[i].
REQ-025 SHALL give set priority over ovf_clr[i] when both occur same cycle.
REQ-026 SHALL load the output register when out_valid=0 or out_ready=1, from the round-robin winner among non-empty FIFOs, popping that FIFO.
REQ-027 SHALL search round-robin starting at (last_grant+1) mod NCH; last_grant updates only on a load.
REQ-028 SHALL deassert out_valid after a handshake (out_valid & out_ready) when all FIFOs are empty.
REQ-029 SHALL hold out_data/out_ch/out_lost stable while out_valid=1 and out_ready=0.
REQ-030 SHALL sustain one word per cycle when out_ready=1 continuously.
REQ-031 SHALL give latency 2 edges: trigger sampled at edge n into empty FIFO with idle output -> out_valid=1 after edge n+1.

Reset
REQ-032 SHALL, on reset low, asynchronously clear: all FIFO pointers (empty), lost_pend, ovf, drop_cnt, out_valid, out_data, out_ch, out_lost to 0; last_grant to NCH-1 (channel 0 first).
REQ-033 SHALL discard all buffered and in-flight words on reset mid-operation; no word delivered after reset deasserts unless newly triggered.
REQ-034 SHALL not require reset release synchronisation internally.

Structure
REQ-035 SHALL place log2 function, default widths, and the out-word field layout in shared package trace_pkg.
REQ-036 SHALL instantiate NCH copies of sub-module trace_fifo (TRACE_W+1 wide, FIFO_D deep, full/empty, simultaneous push/pop).
REQ-037 SHALL connect downstream to trace_buffer as replacement for the fixed priority trace mux.

Verification
REQ-038 Single: reset, ch 2 trigger with 0xDEADBEEF, out_ready=1 -> out_valid after 2 edges, out_data=0xDEADBEEF, out_ch=2, out_lost=0.
REQ-039 Fairness: all 5 channels trigger every cycle, out_ready=1 -> out_ch sequence 0,1,2,3,4,0,... no channel skipped.
REQ-040 Overflow: ch 1 triggers 7 words (FIFO_D=4) with out_ready=0 -> ovf[1]=1, drop_cnt=2 (4 FIFO + 1 output reg held), first word after drops with out_lost=1 on next accepted ch-1 word.
REQ-041 Backpressure: out_ready toggled 1/0 randomly -> out_* stable while stalled, no loss/duplication vs scoreboard.
REQ-042 Set/clear collision: ovf_clr[3]=1 same cycle as ch-3 drop -> ovf[3]=1; ch_en[3]=0 with trigger -> nothing captured.
REQ-043 Reset mid-stream: reset low with 3 FIFOs non-empty and out_valid=1 -> all outputs 0 immediately, nothing emitted after release.
